// File: rtl/ebus_master.sv
`default_nettype none
// ============================================================================
// Module  : ebus_master
// Brief   : EBOX-side EBUS initiator sequencing CONO/CONI/DATAO/DATAI cycles.
// Revision: 1.0 - initial release
// ============================================================================
module ebus_master #(
    parameter int SETUP_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic        req,
    input  logic [0:2]  func,
    input  logic [0:6]  cs,
    input  logic [0:35] wrData,
    output logic        busy,
    output logic        done,
    output logic        nxd,
    output logic [0:35] rdData,
    output logic [0:6]  ebusCS,
    output logic [0:2]  ebusFunc,
    output logic        ebusDemand,
    output logic        ebusDataOE,
    output logic [0:35] ebusDataOut,
    input  logic        ebusXfer,
    input  logic [0:35] ebusDataIn
);

    localparam logic [7:0] SETUP_LAST   = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_DEMAND  = 3'd2,
        S_RELEASE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [0:6]  cs_q, cs_d;
    logic [0:2]  func_q, func_d;
    logic [0:35] wr_q, wr_d;
    logic [0:35] rd_q, rd_d;
    logic        nxd_q, nxd_d;
    logic        active;

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            cs_q    <= 7'd0;
            func_q  <= 3'd0;
            wr_q    <= 36'd0;
            rd_q    <= 36'd0;
            nxd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cs_q    <= cs_d;
            func_q  <= func_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            nxd_q   <= nxd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        cs_d    = cs_q;
        func_d  = func_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        nxd_d   = nxd_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    // Reserved functions never touch the bus; they just report nxd.
                    if (func[0]) begin
                        nxd_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        cs_d    = cs;
                        func_d  = func;
                        wr_d    = wrData;
                        nxd_d   = 1'b0;
                        state_d = S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                if (cnt_q == SETUP_LAST) state_d = S_DEMAND;
            end
            S_DEMAND: begin
                if (ebusXfer) begin
                    if (!func_q[2]) rd_d = ebusDataIn;
                    state_d = S_RELEASE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    nxd_d   = 1'b1;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (!ebusXfer) begin
                    state_d = S_DONE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    nxd_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (state_d != state_q) cnt_d = 8'd0;
    end

    always_comb begin
        active      = (state_q == S_SETUP) || (state_q == S_DEMAND) || (state_q == S_RELEASE);
        busy        = active;
        done        = (state_q == S_DONE);
        nxd         = nxd_q;
        rdData      = rd_q;
        ebusCS      = active ? cs_q : 7'd0;
        ebusFunc    = active ? func_q : 3'd0;
        ebusDemand  = (state_q == S_DEMAND);
        ebusDataOE  = active && func_q[2];
        ebusDataOut = (active && func_q[2]) ? wr_q : 36'd0;
    end

endmodule
`default_nettype wire

// File: tb/tb_ebus_master.sv
`default_nettype none
// ============================================================================
// Module  : tb_ebus_master
// Brief   : Directed self-checking bench for ebus_master.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ebus_master;

    logic        clk = 1'b0;
    logic        RESET;
    logic        req;
    logic [0:2]  func;
    logic [0:6]  cs;
    logic [0:35] wrData;
    logic        busy, done, nxd;
    logic [0:35] rdData;
    logic [0:6]  ebusCS;
    logic [0:2]  ebusFunc;
    logic        ebusDemand, ebusDataOE;
    logic [0:35] ebusDataOut;
    logic        ebusXfer;
    logic [0:35] ebusDataIn;

    int n_checks = 0;
    int n_errors = 0;

    ebus_master #(.SETUP_CYCLES(2), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .RESET(RESET), .req(req), .func(func), .cs(cs), .wrData(wrData),
        .busy(busy), .done(done), .nxd(nxd), .rdData(rdData),
        .ebusCS(ebusCS), .ebusFunc(ebusFunc), .ebusDemand(ebusDemand),
        .ebusDataOE(ebusDataOE), .ebusDataOut(ebusDataOut),
        .ebusXfer(ebusXfer), .ebusDataIn(ebusDataIn)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0o expected %0o", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic all_zero(input string tag);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_done"}, done, 1'b0);
        chk1({tag, "_nxd"}, nxd, 1'b0);
        chkv({tag, "_rdData"}, rdData, 36'd0);
        chkv({tag, "_cs"}, 36'(ebusCS), 36'd0);
        chkv({tag, "_func"}, 36'(ebusFunc), 36'd0);
        chk1({tag, "_demand"}, ebusDemand, 1'b0);
        chk1({tag, "_oe"}, ebusDataOE, 1'b0);
        chkv({tag, "_dout"}, ebusDataOut, 36'd0);
    endtask

    initial begin
        int cnt;
        RESET = 1'b1; req = 1'b0; func = 3'd0; cs = 7'd0; wrData = 36'd0;
        ebusXfer = 1'b0; ebusDataIn = 36'd0;
        step(); step();
        all_zero("reset");
        RESET = 1'b0;
        step();

        // DATAO, device acks after 3 demand clocks
        req = 1'b1; func = 3'd3; cs = 7'o12; wrData = 36'o123456701234;
        step();
        req = 1'b0; wrData = 36'd0;
        chk1("dato_setup_busy", busy, 1'b1);
        chkv("dato_setup_cs", 36'(ebusCS), 36'o12);
        chkv("dato_setup_func", 36'(ebusFunc), 36'd3);
        chk1("dato_setup_oe", ebusDataOE, 1'b1);
        chkv("dato_setup_dout", ebusDataOut, 36'o123456701234);
        chk1("dato_setup_dem0", ebusDemand, 1'b0);
        step();
        chk1("dato_setup_dem1", ebusDemand, 1'b0);
        step();
        chk1("dato_demand", ebusDemand, 1'b1);
        chk1("dato_demand_oe", ebusDataOE, 1'b1);
        chkv("dato_demand_dout", ebusDataOut, 36'o123456701234);
        for (int i = 0; i < 2; i++) begin
            step();
            chk1("dato_demand_hold", ebusDemand, 1'b1);
        end
        ebusXfer = 1'b1;
        step();
        chk1("dato_release_dem", ebusDemand, 1'b0);
        chk1("dato_release_busy", busy, 1'b1);
        chkv("dato_release_cs", 36'(ebusCS), 36'o12);
        ebusXfer = 1'b0;
        step();
        chk1("dato_done", done, 1'b1);
        chk1("dato_done_busy", busy, 1'b0);
        chk1("dato_done_nxd", nxd, 1'b0);
        chk1("dato_done_oe", ebusDataOE, 1'b0);
        chkv("dato_done_cs", 36'(ebusCS), 36'd0);
        // A req presented on the DONE clock must be ignored
        req = 1'b1; func = 3'd1; cs = 7'o5;
        step();
        req = 1'b0;
        chk1("dato_done_once", done, 1'b0);
        chk1("done_clock_req_ignored", busy, 1'b0);
        step();
        chk1("done_clock_req_still_idle", busy, 1'b0);

        // CONI with immediate xfer; also checks S+3 latency
        req = 1'b1; func = 3'd0; cs = 7'o3; ebusDataIn = 36'o777000000017;
        step();
        req = 1'b0;
        chk1("coni_setup_oe", ebusDataOE, 1'b0);
        chkv("coni_setup_dout", ebusDataOut, 36'd0);
        step(); step();
        chk1("coni_demand", ebusDemand, 1'b1);
        chk1("coni_demand_oe", ebusDataOE, 1'b0);
        ebusXfer = 1'b1;
        step();
        ebusXfer = 1'b0;
        ebusDataIn = 36'o111111111111;
        step();
        chk1("coni_done", done, 1'b1);
        chkv("coni_rdData", rdData, 36'o777000000017);
        chk1("coni_nxd", nxd, 1'b0);
        step();

        // Reserved function is rejected without bus activity
        req = 1'b1; func = 3'd5; cs = 7'o1;
        step();
        req = 1'b0;
        chk1("rej_done", done, 1'b1);
        chk1("rej_nxd", nxd, 1'b1);
        chk1("rej_busy", busy, 1'b0);
        chk1("rej_demand", ebusDemand, 1'b0);
        chkv("rej_cs", 36'(ebusCS), 36'd0);
        step();
        chk1("rej_done_once", done, 1'b0);
        chk1("rej_nxd_sticky", nxd, 1'b1);
        chk1("rej_demand2", ebusDemand, 1'b0);

        // CONO clears nxd; a req during busy is ignored
        req = 1'b1; func = 3'd1; cs = 7'o2; wrData = 36'o7;
        step();
        chk1("cono_nxd_clr", nxd, 1'b0);
        func = 3'd5; wrData = 36'o5;
        step();
        req = 1'b0;
        chk1("busy_req_nxd", nxd, 1'b0);
        chkv("busy_req_func", 36'(ebusFunc), 36'd1);
        chkv("busy_req_dout", ebusDataOut, 36'o7);
        step();
        ebusXfer = 1'b1;
        step();
        ebusXfer = 1'b0;
        step();
        chk1("cono_done", done, 1'b1);
        chk1("cono_done_nxd", nxd, 1'b0);
        step();

        // DATAI, no device: demand held exactly 64 clocks
        req = 1'b1; func = 3'd2; cs = 7'o5;
        step();
        req = 1'b0;
        step(); step();
        cnt = 0;
        while (ebusDemand && cnt < 200) begin
            cnt++;
            step();
        end
        chkv("datai_demand_len", 36'(cnt), 36'd64);
        chk1("datai_nxd", nxd, 1'b1);
        step();
        chk1("datai_done", done, 1'b1);
        chkv("datai_rd_unchanged", rdData, 36'o777000000017);
        step();

        // CONO with xfer stuck high after ack: release times out
        req = 1'b1; func = 3'd1; cs = 7'o40; wrData = 36'o5;
        step();
        req = 1'b0;
        chk1("stuck_nxd_clr", nxd, 1'b0);
        step(); step();
        ebusXfer = 1'b1;
        step();
        cnt = 0;
        while (busy && cnt < 200) begin
            cnt++;
            step();
        end
        chkv("stuck_release_len", 36'(cnt), 36'd64);
        chk1("stuck_done", done, 1'b1);
        chk1("stuck_nxd", nxd, 1'b1);
        ebusXfer = 1'b0;
        step();

        // Asynchronous reset in DEMAND
        req = 1'b1; func = 3'd3; cs = 7'o77; wrData = 36'o1;
        step();
        req = 1'b0;
        step(); step();
        chk1("rst_pre_demand", ebusDemand, 1'b1);
        #2;
        RESET = 1'b1;
        #1;
        all_zero("rst_async");
        RESET = 1'b0;
        step(); step();
        chk1("rst_after_busy", busy, 1'b0);

        // Fresh CONI after reset
        req = 1'b1; func = 3'd0; cs = 7'o4; ebusDataIn = 36'o42;
        step();
        req = 1'b0;
        step(); step();
        ebusXfer = 1'b1;
        step();
        ebusXfer = 1'b0;
        step();
        chk1("post_rst_done", done, 1'b1);
        chkv("post_rst_rd", rdData, 36'o42);
        chk1("post_rst_nxd", nxd, 1'b0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
